reg_bus_initiator: RTL
======================

// Module: reg_bus_initiator
// PURPOSE
// - Initiator for the 8-bit select/write/addr/wdata/rdata register bus used by sample_reg_design.
// - Accepts register read/write commands on a valid/ready port and buffers them in a FIFO.
// - Issues one bus access per command and returns one response per command (read data or write ack).
// - Sits between a host/CPU command source and the memory-mapped config register block.
// PARAMETERS
// - DEPTH      4     command FIFO entries; power of 2, >=2
// - GAP_CYCLES 0     extra idle cycles (select=0) after each response handshake, 0..15
// - ADDR_MAX   8'h48 highest mapped address; mapped = addr[2:0]==0 && addr<=ADDR_MAX
// PORTS
// - clk        in   1  clock, all state on posedge
// - rstn       in   1  asynchronous active-low reset
// - cmd_valid  in   1  command offered
// - cmd_ready  out  1  FIFO can accept; equals !full
// - cmd_write  in   1  1=write, 0=read
// - cmd_addr   in   8  register address
// - cmd_wdata  in   8  write data (ignored for reads)
// - rsp_valid  out  1  response available
// - rsp_ready  in   1  response consumer ready
// - rsp_write  out  1  echo of the command's write bit
// - rsp_err    out  1  1=address unmapped/misaligned; no bus access was made
// - rsp_rdata  out  8  read data; 0 for writes and errors
// - select     out  1  bus select, registered
// - write      out  1  bus write strobe, registered
// - addr       out  8  bus address, registered
// - wdata      out  8  bus write data, registered
// - rdata      in   8  bus read data (combinational from responder)
// - busy       out  1  1 when FIFO non-empty or state!=IDLE
// BEHAVIOUR
// - Reset (async, rstn=0): FIFO emptied and state=IDLE. select, write, addr, wdata, rsp_valid,
//   rsp_write, rsp_err, rsp_rdata all 0. busy=0. cmd_ready=1 once rstn deasserts.
// - Mid-operation reset: select drops immediately. Queued and in-flight commands are discarded with no response.
// - FIFO push: cmd_valid&&cmd_ready at an edge. Pop: at the end of ACCESS, or in IDLE for an error command.
//   Push and pop in the same edge leave count unchanged. Write pointers wrap modulo DEPTH.
// - FSM states: IDLE, ACCESS, RESP, GAP.
// - IDLE, FIFO non-empty, head mapped: next edge loads select=1, write/addr/wdata from head; state -> ACCESS.
// - IDLE, head unmapped: next edge pops the head and loads rsp_valid=1, rsp_err=1, rsp_rdata=0; state -> RESP.
//   select stays 0 throughout.
// - ACCESS (exactly 1 cycle, select=1): at the closing edge:
//   - the responder commits a write;
//   - the initiator captures rdata into rsp_rdata for reads (0 for writes) and pops the FIFO;
//   - select/write return to 0; rsp_valid=1, rsp_err=0; state -> RESP.
// - addr/wdata hold their last value while select=0.
// - RESP: rsp_* held stable while rsp_valid&&!rsp_ready.
//   On rsp_valid&&rsp_ready: rsp_valid=0, then state -> GAP (counter=GAP_CYCLES) if GAP_CYCLES>0, else IDLE.
// - GAP: counter decrements each cycle; at 1 -> IDLE.
// - Only one bus access outstanding. No new access is issued while rsp_valid=1.
// - Minimum access period with GAP_CYCLES=0 and rsp_ready=1: 3 cycles (select, handshake, idle).
// - Capacity: DEPTH queued commands plus 1 in RESP. cmd_ready=0 only when count==DEPTH.
// - Responses are returned in command order. A read after a write to the same address returns the new data.
// TESTING
// - T1 write 0x00=0xA5, then read 0x00:
//   - select high 1 cycle each, write=1 then 0;
//   - responses: {write=1,err=0,rdata=0} then {write=0,rdata=0xA5}.
// - T2 reads 0x40 and 0x48 after reset -> rdata 0x6E and 0x0D. A write 0x40=0xFF then read 0x40 -> still 0x6E.
// - T3 rsp_ready held 0, push commands back to back:
//   - exactly DEPTH+1=5 accepted, then cmd_ready=0;
//   - release rsp_ready -> 5 in-order responses.
// - T4 read 0x09 and read 0x50 -> rsp_err=1, rdata=0, select never asserted; next valid command still served.
// - T5 rstn pulsed low during ACCESS with 3 queued -> select=0 immediately, no responses, busy=0, cmd_ready=1.
// - T6 GAP_CYCLES=2, rsp_ready=1, two reads -> select rising edges exactly 5 cycles apart.

Source files
------------

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator
// Initiator for an 8-bit select/write/addr/wdata/rdata register bus. Register
// read/write commands are accepted on a valid/ready port and buffered in a
// FIFO. Each command becomes one bus access, and each command gets one
// response (read data or write ack) back on a valid/ready port.
//
// Ports
//   clk, rstn                      clock (posedge), async active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = !full)
//   cmd_write/cmd_addr/cmd_wdata   command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_write/rsp_err/rsp_rdata    response fields (err = unmapped address)
//   select/write/addr/wdata        registered bus outputs
//   rdata                          bus read data (combinational from responder)
//   busy                           FIFO non-empty or FSM not idle
module reg_bus_initiator #(
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] ADDR_MAX   = 8'h48
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       select,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       busy
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]      GAP_INIT = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Mapped registers sit on 8-byte boundaries up to ADDR_MAX.
  function automatic logic is_mapped(input logic [7:0] a);
    return (a[2:0] == 3'b000) && (a <= ADDR_MAX);
  endfunction

  // FIFO entry layout: {write, addr[7:0], wdata[7:0]}
  logic [16:0]   fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic          select_q, select_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;

  logic          push_s;
  logic          pop_s;
  logic [16:0]   head_s;
  logic          head_write_s;
  logic [7:0]    head_addr_s;
  logic [7:0]    head_wdata_s;

  assign head_s       = fifo_mem_q[rd_ptr_q];
  assign head_write_s = head_s[16];
  assign head_addr_s  = head_s[15:8];
  assign head_wdata_s = head_s[7:0];

  assign cmd_ready = (count_q != FULL_CNT);
  assign push_s    = cmd_valid && cmd_ready;

  // FIFO pointer and occupancy next-state; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= 17'd0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    gap_cnt_d   = gap_cnt_q;
    pop_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          if (is_mapped(head_addr_s)) begin
            select_d = 1'b1;
            write_d  = head_write_s;
            addr_d   = head_addr_s;
            wdata_d  = head_wdata_s;
            state_d  = ACCESS;
          end else begin
            // Unmapped: answer with an error straight away, never touching the bus.
            pop_s       = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_write_d = head_write_s;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
            state_d     = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Single-cycle access: responder commits/drives rdata during this cycle.
        pop_s       = 1'b1;
        select_d    = 1'b0;
        write_d     = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = write_q ? 8'h00 : rdata;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (GAP_INIT != 4'd0) begin
            gap_cnt_d = GAP_INIT;
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d = 4'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          state_d   = GAP;
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 1'b0;
        write_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered bus/response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      select_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign select    = select_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (count_q != {CW{1'b0}}) || (state_q != IDLE);

endmodule
